mdu_hilo: RTL and testbench
===========================

Name: mdu_hilo

Overview:
Multiply/divide unit of the E stage in the 5-stage pipelined MIPS core.
- Executes mult/multu/div/divu with fixed multi-cycle latency.
- Handles mthi/mtlo writes and holds the architectural HI/LO registers.
- hi_out/lo_out feed the E-stage result 4:1 mux for mfhi/mflo; busy feeds the hazard unit's stall logic.

Parameters:
MULT_LAT, 5, cycles busy for mult/multu (legal range >= 1)
DIV_LAT, 10, cycles busy for div/divu (legal range >= 1)

Ports:
clk  input  1  clock; all state changes on the rising edge
reset  input  1  synchronous, active-high reset
req  input  1  CP0 interrupt/exception request this cycle; suppresses any new operation
start  input  1  launch the operation named by mdu_op (mult/multu/div/divu only)
mdu_op  input  4  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO; others treated as NONE
src_a  input  32  rs operand (forwarded)
src_b  input  32  rt operand (forwarded)
busy  output  1  registered; high while an operation is in flight
hi_out  output  32  architectural HI register
lo_out  output  32  architectural LO register

Behaviour:
- Reset: HI=0, LO=0, busy=0, counter=0, pending results cleared. Reset mid-operation aborts it; no HI/LO write occurs afterwards.
- Launch: at edge T, a new operation launches only if start=1, req=0, busy=0 and mdu_op is in 1..4.
  - Operands and op are latched.
  - The result is computed behaviourally into pending_hi/pending_lo registers.
  - counter loads MULT_LAT or DIV_LAT; busy=1 from the edge of T.
- Countdown: counter decrements every cycle while busy=1.
  - On the edge where counter==1: HI/LO <= pending values, busy <= 0, counter <= 0.
  - Net timing: busy is high for exactly LAT cycles, and the new HI/LO is visible in the first cycle busy reads 0.
- start with busy=1: ignored. The hazard unit stalls on (start|busy), so this is a protocol error. The in-flight operation continues unaffected.
- Moves: MTHI/MTLO apply when req=0 and busy=0, independent of start. HI (or LO) <= src_a at that edge with single-cycle effect. MTHI/MTLO while busy=1 are ignored.
- req=1: no launch and no MTHI/MTLO in that cycle. An operation already in flight is NOT aborted; it belongs to an older instruction and completes normally.
- MULT: signed 32x32 to 64; HI=product[63:32], LO=product[31:0].
- MULTU: unsigned 32x32 to 64; same split.
- DIV: LO = quotient truncated toward zero; HI = remainder, with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- DIVU: unsigned quotient in LO, remainder in HI.
- Divide by zero (src_b==0, DIV or DIVU): busy still asserts for DIV_LAT cycles; HI/LO are left unchanged at completion.
- hi_out/lo_out are driven directly from the registers; there is no bypass of pending results.

Decomposition:
- Shared package (mdu_pkg) holds:
  - mdu_op encodings (MDU_NONE..MDU_MTLO);
  - default latency constants MULT_LAT_DEF=5 and DIV_LAT_DEF=10.
- The E-stage decoder and hazard unit import the same package.
- No sub-module: arithmetic is behavioural `*` and `/`/`%` inside the block, and the single counter/FSM is small.

Test Plan:
- Signed multiply: reset, then start MULT with a=0xFFFFFFFF, b=0x00000002.
  - busy=1 for 5 cycles.
  - Then HI=0xFFFFFFFF, LO=0xFFFFFFFE.
- Unsigned multiply: MULTU with the same operands gives HI=0x00000001, LO=0xFFFFFFFE after 5 busy cycles.
- Signed divide: DIV a=0xFFFFFFF9 (-7), b=2.
  - busy for 10 cycles.
  - Then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - Repeat with a=0x80000000, b=0xFFFFFFFF: LO=0x80000000, HI=0.
- Divide by zero, then moves:
  - MTHI 0x12345678, then MTLO 0x9ABCDEF0, then DIVU a=7, b=0.
  - Required: busy for 10 cycles, then HI=0x12345678, LO=0x9ABCDEF0.
- Interrupt, busy and reset interactions:
  - start MULT together with req=1: busy stays 0 and HI/LO unchanged.
  - MTLO 0x55 during busy: ignored.
  - req=1 during an in-flight DIV: the DIV still completes.
  - reset asserted at busy cycle 3 of a DIV: busy=0, HI=LO=0 from the next cycle, and they remain 0.

Source files
------------

// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_pkg
//  Description : Shared definitions for the E-stage multiply/divide unit:
//                operation encodings, default latencies and FSM states.
//                Also imported by the E-stage decoder and the hazard unit.
//  Revision    : 1.0  initial release
// ============================================================================
package mdu_pkg;

  // Operation encodings carried on mdu_op; unlisted codes behave as NONE.
  typedef enum logic [3:0] {
    MDU_NONE  = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MTHI  = 4'd5,
    MDU_MTLO  = 4'd6
  } mdu_op_e;

  // Default busy durations for the multiply and divide families.
  localparam int MULT_LAT_DEF = 5;
  localparam int DIV_LAT_DEF  = 10;

  // Two-state controller: idle, or counting down an operation in flight.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mdu_state_e;

  // True for the multi-cycle arithmetic operations that occupy the unit.
  function automatic logic is_arith_op(input logic [3:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU) ||
           (op == MDU_DIV)  || (op == MDU_DIVU);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_hilo.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_hilo
//  Description : Multiply/divide unit with architectural HI/LO registers.
//                mult/multu/div/divu run for a fixed number of busy cycles;
//                the result is captured at launch and committed to HI/LO
//                on the final busy cycle. mthi/mtlo write in one cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module mdu_hilo
  import mdu_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        start,
  input  logic [3:0]  mdu_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        busy,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);

  localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int CW      = $clog2(MAX_LAT + 1);

  localparam logic [CW-1:0] C_MULT_CNT = CW'(MULT_LAT);
  localparam logic [CW-1:0] C_DIV_CNT  = CW'(DIV_LAT);
  localparam logic [CW-1:0] C_CNT_ONE  = CW'(1);

  mdu_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   hi_q, hi_d;
  logic [31:0]   lo_q, lo_d;
  logic [31:0]   pend_hi_q, pend_hi_d;
  logic [31:0]   pend_lo_q, pend_lo_d;
  logic          pend_wr_q, pend_wr_d;

  logic [63:0]   w_prod_s;
  logic [63:0]   w_prod_u;
  logic [31:0]   w_a_mag;
  logic [31:0]   w_b_mag;
  logic [31:0]   w_mag_den;
  logic [31:0]   w_mag_q;
  logic [31:0]   w_mag_r;
  logic [31:0]   w_quot_s;
  logic [31:0]   w_rem_s;
  logic [31:0]   w_u_den;
  logic [31:0]   w_quot_u;
  logic [31:0]   w_rem_u;
  logic          w_launch;
  logic          w_move_ok;

  // Behavioural arithmetic on the live operands; the signed divide works on
  // magnitudes so 0x80000000 / -1 wraps to 0x80000000 with zero remainder.
  always_comb begin
    w_prod_s  = {{32{src_a[31]}}, src_a} * {{32{src_b[31]}}, src_b};
    w_prod_u  = {32'd0, src_a} * {32'd0, src_b};
    w_a_mag   = src_a[31] ? (~src_a + 32'd1) : src_a;
    w_b_mag   = src_b[31] ? (~src_b + 32'd1) : src_b;
    // A zero divisor never commits, so any nonzero stand-in keeps the
    // divider well defined.
    w_mag_den = (w_b_mag == 32'd0) ? 32'd1 : w_b_mag;
    w_mag_q   = w_a_mag / w_mag_den;
    w_mag_r   = w_a_mag % w_mag_den;
    w_quot_s  = (src_a[31] ^ src_b[31]) ? (~w_mag_q + 32'd1) : w_mag_q;
    w_rem_s   = src_a[31] ? (~w_mag_r + 32'd1) : w_mag_r;
    w_u_den   = (src_b == 32'd0) ? 32'd1 : src_b;
    w_quot_u  = src_a / w_u_den;
    w_rem_u   = src_a % w_u_den;
  end

  assign w_move_ok = !req && (state_q == ST_IDLE);
  assign w_launch  = w_move_ok && start && is_arith_op(mdu_op);

  // Next-state logic: launch, countdown/commit, and single-cycle moves.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_wr_d = pend_wr_q;
    case (state_q)
      ST_IDLE: begin
        if (w_launch) begin
          state_d   = ST_BUSY;
          pend_wr_d = 1'b1;
          case (mdu_op)
            MDU_MULT: begin
              cnt_d     = C_MULT_CNT;
              pend_hi_d = w_prod_s[63:32];
              pend_lo_d = w_prod_s[31:0];
            end
            MDU_MULTU: begin
              cnt_d     = C_MULT_CNT;
              pend_hi_d = w_prod_u[63:32];
              pend_lo_d = w_prod_u[31:0];
            end
            MDU_DIV: begin
              cnt_d     = C_DIV_CNT;
              pend_hi_d = w_rem_s;
              pend_lo_d = w_quot_s;
              pend_wr_d = (src_b != 32'd0);
            end
            default: begin
              cnt_d     = C_DIV_CNT;
              pend_hi_d = w_rem_u;
              pend_lo_d = w_quot_u;
              pend_wr_d = (src_b != 32'd0);
            end
          endcase
        end
        if (w_move_ok && (mdu_op == MDU_MTHI)) begin
          hi_d = src_a;
        end
        if (w_move_ok && (mdu_op == MDU_MTLO)) begin
          lo_d = src_a;
        end
      end
      ST_BUSY: begin
        if (cnt_q == C_CNT_ONE) begin
          state_d   = ST_IDLE;
          cnt_d     = '0;
          pend_wr_d = 1'b0;
          if (pend_wr_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
        end else begin
          cnt_d = cnt_q - C_CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State and data registers; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      pend_wr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_wr_q <= pend_wr_d;
    end
  end

  assign busy   = (state_q == ST_BUSY);
  assign hi_out = hi_q;
  assign lo_out = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_mdu_hilo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mdu_hilo
//  Description : Scoreboard bench for mdu_hilo. Launches push the expected
//                HI/LO and busy length; a monitor pops on each busy fall.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mdu_hilo;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic        start;
  logic [3:0]  mdu_op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        busy;
  logic [31:0] hi_out;
  logic [31:0] lo_out;

  mdu_hilo #(.MULT_LAT(5), .DIV_LAT(10)) dut (
    .clk(clk), .reset(reset), .req(req), .start(start), .mdu_op(mdu_op),
    .src_a(src_a), .src_b(src_b), .busy(busy), .hi_out(hi_out), .lo_out(lo_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
    string       name;
  } exp_t;

  exp_t        scb[$];
  int          tests = 0;
  int          fails = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;
  bit          abort_pending = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: architectural results from plain 64-bit arithmetic.
  function automatic void model(input logic [3:0] op, input logic [31:0] a,
                                input logic [31:0] b, output logic [31:0] h,
                                output logic [31:0] l);
    longint      sp, sa, sd, q, r;
    bit   [63:0] up;
    h = m_hi;
    l = m_lo;
    case (op)
      MDU_MULT: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        h = sp[63:32]; l = sp[31:0];
      end
      MDU_MULTU: begin
        up = {32'd0, a} * {32'd0, b};
        h = up[63:32]; l = up[31:0];
      end
      MDU_DIV: if (b != 32'd0) begin
        sa = longint'($signed(a)); sd = longint'($signed(b));
        q = sa / sd; r = sa % sd;
        h = r[31:0]; l = q[31:0];
      end
      MDU_DIVU: if (b != 32'd0) begin
        h = a % b; l = a / b;
      end
      default: ;
    endcase
  endfunction

  // Monitor: count busy cycles; on each busy fall compare against the queue.
  initial begin
    int   cnt = 0;
    bit   prev = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (busy === 1'b1) begin
        cnt++;
      end else begin
        if (prev) begin
          if (abort_pending) begin
            abort_pending = 1'b0;
          end else if (scb.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_done: busy fell after %0d cycles, nothing expected", cnt);
          end else begin
            e = scb.pop_front();
            chk({e.name, "_hi"}, hi_out, e.hi);
            chk({e.name, "_lo"}, lo_out, e.lo);
            chk({e.name, "_busylen"}, 32'(cnt), 32'(e.lat));
          end
        end
        cnt = 0;
      end
      prev = (busy === 1'b1);
    end
  end

  task automatic launch(input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input bit r, input string nm);
    exp_t        e;
    logic [31:0] h, l;
    @(negedge clk);
    start = 1'b1; mdu_op = op; src_a = a; src_b = b; req = r;
    if (!r) begin
      model(op, a, b, h, l);
      m_hi = h; m_lo = l;
      e.hi = h; e.lo = l; e.name = nm;
      e.lat = (op == MDU_MULT || op == MDU_MULTU) ? 5 : 10;
      scb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0; mdu_op = MDU_NONE; req = 1'b0;
    if (r) begin
      chk({nm, "_req_busy"}, 32'(busy), 32'd0);
      chk({nm, "_req_hi"}, hi_out, m_hi);
      chk({nm, "_req_lo"}, lo_out, m_lo);
    end
  endtask

  task automatic move(input logic [3:0] op, input logic [31:0] v, input bit r, input string nm);
    @(negedge clk);
    mdu_op = op; src_a = v; req = r;
    if (!r) begin
      if (op == MDU_MTHI) m_hi = v;
      else                m_lo = v;
    end
    @(negedge clk);
    mdu_op = MDU_NONE; req = 1'b0;
    chk({nm, "_hi"}, hi_out, m_hi);
    chk({nm, "_lo"}, lo_out, m_lo);
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while (scb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (scb.size() != 0) begin
      tests++; fails++;
      $display("FAIL %s_timeout: %0d results outstanding, required 0", nm, scb.size());
      scb.delete();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  op;
    logic [31:0] a, b;
    bit          r;
    reset = 1'b1; req = 1'b0; start = 1'b0; mdu_op = MDU_NONE;
    src_a = 32'd0; src_b = 32'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_hi", hi_out, 32'd0);
    chk("reset_lo", lo_out, 32'd0);

    // Directed cases with the known architectural answers.
    launch(MDU_MULT, 32'hFFFFFFFF, 32'h2, 1'b0, "mult");
    wait_done("mult");
    chk("mult_plan_hi", hi_out, 32'hFFFFFFFF);
    chk("mult_plan_lo", lo_out, 32'hFFFFFFFE);
    launch(MDU_MULTU, 32'hFFFFFFFF, 32'h2, 1'b0, "multu");
    wait_done("multu");
    chk("multu_plan_hi", hi_out, 32'h00000001);
    launch(MDU_DIV, 32'hFFFFFFF9, 32'h2, 1'b0, "div_neg");
    wait_done("div_neg");
    chk("div_neg_plan_lo", lo_out, 32'hFFFFFFFD);
    chk("div_neg_plan_hi", hi_out, 32'hFFFFFFFF);
    launch(MDU_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0, "div_ovf");
    wait_done("div_ovf");
    chk("div_ovf_plan_lo", lo_out, 32'h80000000);
    chk("div_ovf_plan_hi", hi_out, 32'h00000000);

    move(MDU_MTHI, 32'h12345678, 1'b0, "mthi");
    move(MDU_MTLO, 32'h9ABCDEF0, 1'b0, "mtlo");
    launch(MDU_DIVU, 32'd7, 32'd0, 1'b0, "divu_zero");
    wait_done("divu_zero");
    chk("divu_zero_plan_hi", hi_out, 32'h12345678);
    chk("divu_zero_plan_lo", lo_out, 32'h9ABCDEF0);

    // Launch suppressed by an interrupt request.
    launch(MDU_MULT, 32'd3, 32'd4, 1'b1, "mult_req");

    // Start and MTLO while busy are both ignored.
    launch(MDU_MULT, 32'd3, 32'd4, 1'b0, "mult_busy");
    start = 1'b1; mdu_op = MDU_DIVU; src_a = 32'd1; src_b = 32'd1;
    @(negedge clk);
    start = 1'b0; mdu_op = MDU_MTLO; src_a = 32'h55;
    @(negedge clk);
    mdu_op = MDU_NONE;
    wait_done("mult_busy");

    // req during an in-flight divide does not abort it.
    launch(MDU_DIV, 32'd100, 32'hFFFFFFF9, 1'b0, "div_req");
    req = 1'b1;
    repeat (4) @(negedge clk);
    req = 1'b0;
    wait_done("div_req");

    // Reset in busy cycle 3 of a divide: nothing is committed afterwards.
    launch(MDU_DIV, 32'd1000, 32'd3, 1'b0, "div_rst");
    @(negedge clk);
    @(negedge clk);
    scb.delete();
    abort_pending = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_hi = 32'd0; m_lo = 32'd0;
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_hi", hi_out, 32'd0);
    chk("rst_mid_lo", lo_out, 32'd0);
    repeat (12) @(negedge clk);
    chk("rst_hold_busy", 32'(busy), 32'd0);
    chk("rst_hold_hi", hi_out, 32'd0);
    chk("rst_hold_lo", lo_out, 32'd0);

    // Randomized mix of operations, moves, zero divisors and requests.
    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(1, 6));
      a  = $urandom;
      b  = ($urandom_range(0, 5) == 0) ? 32'd0 :
           ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 20)) : $urandom;
      if ($urandom_range(0, 3) == 0) a = 32'($signed(-$urandom_range(1, 50)));
      r  = ($urandom_range(0, 5) == 0);
      if (op <= MDU_DIVU) begin
        launch(op, a, b, r, "rand_op");
        wait_done("rand_op");
      end else begin
        move(op, a, r, "rand_move");
      end
    end

    chk("scoreboard_empty", 32'(scb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
